// File: rtl/core_sequencer_pkg.sv
// Shared types for the RV32I control sequencer: ALU/branch encodings,
// the decoded control word, sequencer states and immediate field layouts.
// Optional feature macro: CORE_ILLEGAL_HALT_EN adds the absorbing S_HALT state.
package core_sequencer_pkg;

  typedef enum logic [3:0] {
    ALU_FUNC_UNKNOWN = 4'd0,
    ALU_FUNC_ADD,
    ALU_FUNC_SUB,
    ALU_FUNC_SLL,
    ALU_FUNC_SLT,
    ALU_FUNC_SLTU,
    ALU_FUNC_XOR,
    ALU_FUNC_SRL,
    ALU_FUNC_SRA,
    ALU_FUNC_OR,
    ALU_FUNC_AND,
    ALU_FUNC_SEQ
  } alu_func_t;

  typedef enum logic [1:0] {
    BRANCH_NONE,
    BRANCH_TRUE,
    BRANCH_FALSE
  } branch_t;

  typedef struct packed {
    alu_func_t alu_func;
    logic      use_imm;
    logic      rd_write;
    branch_t   branch;
  } control_t;

  localparam control_t CTRL_NOP = '{alu_func: ALU_FUNC_UNKNOWN, use_imm: 1'b0,
                                    rd_write: 1'b0, branch: BRANCH_NONE};

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_SR   = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;

  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

`ifdef CORE_ILLEGAL_HALT_EN
  typedef enum logic [2:0] {S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} seq_state_t;
`else
  typedef enum logic [2:0] {S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_WB} seq_state_t;
`endif

  function automatic logic [31:0] imm_i(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:20]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ir);
    return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/core_sequencer_instr_decoder.sv
// Combinational RV32I decoder for OP, OP_IMM and BRANCH instructions.
// Produces the control word, immediate, register indices and an illegal flag;
// the control word is not meaningful when illegal is set.
module instr_decoder
  import core_sequencer_pkg::*;
(
  input  logic [31:0] i_instr,
  output control_t    o_ctrl,
  output logic [31:0] o_imm,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic        o_illegal
);

  logic [6:0] w_opcode;
  logic [6:0] w_funct7;
  logic [2:0] w_funct3;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  assign o_rd     = i_instr[11:7];
  assign o_rs1    = i_instr[19:15];
  assign o_rs2    = i_instr[24:20];

  // Decode opcode/funct fields into ALU operation, operand select and branch sense
  always_comb begin
    o_ctrl    = CTRL_NOP;
    o_imm     = '0;
    o_illegal = 1'b0;
    case (w_opcode)
      OPCODE_OP: begin
        o_ctrl.rd_write = 1'b1;
        case (w_funct3)
          FUNCT3_ADD:  o_ctrl.alu_func = w_funct7[5] ? ALU_FUNC_SUB : ALU_FUNC_ADD;
          FUNCT3_SLL:  o_ctrl.alu_func = ALU_FUNC_SLL;
          FUNCT3_SLT:  o_ctrl.alu_func = ALU_FUNC_SLT;
          FUNCT3_SLTU: o_ctrl.alu_func = ALU_FUNC_SLTU;
          FUNCT3_XOR:  o_ctrl.alu_func = ALU_FUNC_XOR;
          FUNCT3_SR:   o_ctrl.alu_func = w_funct7[5] ? ALU_FUNC_SRA : ALU_FUNC_SRL;
          FUNCT3_OR:   o_ctrl.alu_func = ALU_FUNC_OR;
          default:     o_ctrl.alu_func = ALU_FUNC_AND;
        endcase
        if ((w_funct7 != FUNCT7_BASE) &&
            !((w_funct7 == FUNCT7_ALT) && ((w_funct3 == FUNCT3_ADD) || (w_funct3 == FUNCT3_SR))))
          o_illegal = 1'b1;
      end
      OPCODE_OP_IMM: begin
        o_ctrl.rd_write = 1'b1;
        o_ctrl.use_imm  = 1'b1;
        o_imm           = imm_i(i_instr);
        case (w_funct3)
          FUNCT3_ADD:  o_ctrl.alu_func = ALU_FUNC_ADD;
          FUNCT3_SLL: begin
            o_ctrl.alu_func = ALU_FUNC_SLL;
            if (w_funct7 != FUNCT7_BASE) o_illegal = 1'b1;
          end
          FUNCT3_SLT:  o_ctrl.alu_func = ALU_FUNC_SLT;
          FUNCT3_SLTU: o_ctrl.alu_func = ALU_FUNC_SLTU;
          FUNCT3_XOR:  o_ctrl.alu_func = ALU_FUNC_XOR;
          FUNCT3_SR:   o_ctrl.alu_func = i_instr[30] ? ALU_FUNC_SRA : ALU_FUNC_SRL;
          FUNCT3_OR:   o_ctrl.alu_func = ALU_FUNC_OR;
          default:     o_ctrl.alu_func = ALU_FUNC_AND;
        endcase
      end
      OPCODE_BRANCH: begin
        o_imm = imm_b(i_instr);
        case (w_funct3)
          FUNCT3_BEQ:  begin o_ctrl.alu_func = ALU_FUNC_SEQ;  o_ctrl.branch = BRANCH_TRUE;  end
          FUNCT3_BNE:  begin o_ctrl.alu_func = ALU_FUNC_SEQ;  o_ctrl.branch = BRANCH_FALSE; end
          FUNCT3_BLT:  begin o_ctrl.alu_func = ALU_FUNC_SLT;  o_ctrl.branch = BRANCH_TRUE;  end
          FUNCT3_BGE:  begin o_ctrl.alu_func = ALU_FUNC_SLT;  o_ctrl.branch = BRANCH_FALSE; end
          FUNCT3_BLTU: begin o_ctrl.alu_func = ALU_FUNC_SLTU; o_ctrl.branch = BRANCH_TRUE;  end
          FUNCT3_BGEU: begin o_ctrl.alu_func = ALU_FUNC_SLTU; o_ctrl.branch = BRANCH_FALSE; end
          default:     o_illegal = 1'b1;
        endcase
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control sequencer: BOOT -> FETCH -> DECODE -> EXEC -> WB.
// Owns the PC, fetches over a req/ack port and drives the ALU/register file.
// Optional feature macro: CORE_ILLEGAL_HALT_EN (illegal instruction halts the core
// and adds the halt port); without it illegal instructions retire as NOPs.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output alu_func_t   alu_func,
  output logic        alu_use_imm,
  output logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic [4:0]  rd_addr,
  output logic        rd_we,
  output logic [31:0] rd_wdata
`ifdef CORE_ILLEGAL_HALT_EN
  ,
  output logic        halt
`endif
);

  seq_state_t  r_state;
  seq_state_t  w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_next_pc;
  logic [31:0] r_ir;
  control_t    r_ctrl;
  logic [31:0] r_imm;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rd;
  logic [31:0] r_wdata;

  control_t    w_ctrl;
  logic [31:0] w_imm;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic        w_illegal;
  logic        w_taken;

  instr_decoder u_decoder (
    .i_instr   (r_ir),
    .o_ctrl    (w_ctrl),
    .o_imm     (w_imm),
    .o_rs1     (w_rs1),
    .o_rs2     (w_rs2),
    .o_rd      (w_rd),
    .o_illegal (w_illegal)
  );

  assign w_taken = (r_ctrl.branch != BRANCH_NONE) &&
                   (alu_result[0] ^ (r_ctrl.branch == BRANCH_FALSE));

  assign imem_addr = r_pc;
  assign rs1_addr  = r_rs1;
  assign rs2_addr  = r_rs2;
  assign rd_addr   = r_rd;
  assign imm       = r_imm;
  assign rd_wdata  = r_wdata;

  // State register; reset abandons any in-flight fetch or writeback
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_BOOT;
    else     r_state <= w_next_state;
  end

  // Next-state logic and state-decoded control outputs
  always_comb begin
    w_next_state = r_state;
    imem_req     = 1'b0;
    alu_func     = ALU_FUNC_UNKNOWN;
    alu_use_imm  = 1'b0;
    rd_we        = 1'b0;
`ifdef CORE_ILLEGAL_HALT_EN
    halt         = 1'b0;
`endif
    case (r_state)
      S_BOOT:  w_next_state = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) w_next_state = S_DECODE;
      end
`ifdef CORE_ILLEGAL_HALT_EN
      S_DECODE: w_next_state = w_illegal ? S_HALT : S_EXEC;
      S_HALT:   halt = 1'b1;
`else
      S_DECODE: w_next_state = S_EXEC;
`endif
      S_EXEC: begin
        alu_func     = r_ctrl.alu_func;
        alu_use_imm  = r_ctrl.use_imm;
        w_next_state = S_WB;
      end
      S_WB: begin
        rd_we        = r_ctrl.rd_write && (r_rd != 5'd0);
        w_next_state = S_FETCH;
      end
      default: w_next_state = S_BOOT;
    endcase
  end

  // Datapath registers: latch instruction, register decode, sample ALU, update PC.
  // Illegal encodings are registered as a NOP control word so they retire without effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_next_pc <= RESET_PC;
      r_ir      <= '0;
      r_ctrl    <= CTRL_NOP;
      r_imm     <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_wdata   <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (imem_ack) r_ir <= imem_rdata;
        S_DECODE: begin
          r_ctrl <= w_illegal ? CTRL_NOP : w_ctrl;
          r_imm  <= w_imm;
          r_rs1  <= w_rs1;
          r_rs2  <= w_rs2;
          r_rd   <= w_rd;
        end
        S_EXEC: begin
          r_wdata   <= alu_result;
          r_next_pc <= w_taken ? (r_pc + r_imm) : (r_pc + 32'd4);
        end
        S_WB:    r_pc <= r_next_pc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: expected fetch addresses and
// writebacks are queued as stimulus is issued and checked by a monitor.
// Supports builds with and without CORE_ILLEGAL_HALT_EN.
module tb_core_sequencer;
  import core_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  alu_func_t   alu_func;
  logic        alu_use_imm;
  logic [31:0] imm;
  logic [31:0] alu_result = '0;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic [31:0] rd_wdata;
`ifdef CORE_ILLEGAL_HALT_EN
  logic        halt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] fetch_q[$];
  logic [36:0] wb_q[$];

  always #5 clk = ~clk;

  core_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .alu_func    (alu_func),
    .alu_use_imm (alu_use_imm),
    .imm         (imm),
    .alu_result  (alu_result),
    .rd_addr     (rd_addr),
    .rd_we       (rd_we),
    .rd_wdata    (rd_wdata)
`ifdef CORE_ILLEGAL_HALT_EN
    ,
    .halt        (halt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Scoreboard monitor: new fetch requests and writeback pulses
  logic r_req_d = 1'b0;
  always @(negedge clk) begin
    logic [36:0] e;
    if (rst) begin
      r_req_d = 1'b0;
    end else begin
      if (imem_req && !r_req_d) begin
        if (fetch_q.size() == 0) chk("fetch_unexpected", 32'(fetch_q.size()), 32'd1);
        else chk("fetch_addr", imem_addr, fetch_q.pop_front());
      end
      if (rd_we) begin
        if (wb_q.size() == 0) chk("wb_spurious", 32'(rd_we), 32'd0);
        else begin
          e = wb_q.pop_front();
          chk("wb_rd", 32'(rd_addr), 32'(e[36:32]));
          chk("wb_data", rd_wdata, e[31:0]);
        end
      end
      r_req_d = imem_req;
    end
  end

  // Runs one instruction starting at the first FETCH negedge, ending at the next FETCH
  task automatic run_instr(input string nm, input logic [31:0] instr, input logic [31:0] alu_val,
                           input int unsigned waits, input logic [31:0] e_pc,
                           input alu_func_t e_func, input logic e_use_imm, input logic [31:0] e_imm,
                           input logic [4:0] e_rs1, input logic [4:0] e_rs2, input logic [4:0] e_rd,
                           input logic e_we, input logic [31:0] e_next);
    chk({nm, "_req"}, 32'(imem_req), 32'd1);
    chk({nm, "_addr"}, imem_addr, e_pc);
    for (int unsigned i = 0; i < waits; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk({nm, "_wait_req"}, 32'(imem_req), 32'd1);
      chk({nm, "_wait_addr"}, imem_addr, e_pc);
    end
    imem_ack   = 1'b1;
    imem_rdata = instr;
    @(negedge clk);
    imem_rdata = 32'hDEAD_BEEF;
    chk({nm, "_dec_req"}, 32'(imem_req), 32'd0);
    chk({nm, "_dec_func"}, 32'(alu_func), 32'(ALU_FUNC_UNKNOWN));
    @(negedge clk);
    alu_result = alu_val;
    if (e_we) wb_q.push_back({e_rd, alu_val});
    chk({nm, "_func"}, 32'(alu_func), 32'(e_func));
    chk({nm, "_use_imm"}, 32'(alu_use_imm), 32'(e_use_imm));
    chk({nm, "_imm"}, imm, e_imm);
    chk({nm, "_rs1"}, 32'(rs1_addr), 32'(e_rs1));
    chk({nm, "_rs2"}, 32'(rs2_addr), 32'(e_rs2));
    chk({nm, "_rd"}, 32'(rd_addr), 32'(e_rd));
    @(negedge clk);
    chk({nm, "_wb_req"}, 32'(imem_req), 32'd0);
    chk({nm, "_wb_func"}, 32'(alu_func), 32'(ALU_FUNC_UNKNOWN));
    chk({nm, "_wb_use_imm"}, 32'(alu_use_imm), 32'd0);
    fetch_q.push_back(e_next);
    @(negedge clk);
    chk({nm, "_wb_pending"}, 32'(wb_q.size()), 32'd0);
    chk({nm, "_next_req"}, 32'(imem_req), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    fetch_q.push_back(32'h0);
    imem_ack = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_we", 32'(rd_we), 32'd0);
    chk("rst_wdata", rd_wdata, 32'd0);
    chk("rst_rd", 32'(rd_addr), 32'd0);
    chk("rst_rs1", 32'(rs1_addr), 32'd0);
    chk("rst_rs2", 32'(rs2_addr), 32'd0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_func", 32'(alu_func), 32'(ALU_FUNC_UNKNOWN));
    chk("rst_use_imm", 32'(alu_use_imm), 32'd0);
`ifdef CORE_ILLEGAL_HALT_EN
    chk("rst_halt", 32'(halt), 32'd0);
`endif
    rst = 1'b0;
    chk("boot_req", 32'(imem_req), 32'd0);
    @(negedge clk);

    run_instr("addi",   32'h00500093, 32'd5,          0,  32'd0,  ALU_FUNC_ADD,  1'b1, 32'd5,          5'd0, 5'd5, 5'd1,  1'b1, 32'd4);
    run_instr("sub",    32'h402081B3, 32'hFFFF_FFFD,  0,  32'd4,  ALU_FUNC_SUB,  1'b0, 32'd0,          5'd1, 5'd2, 5'd3,  1'b1, 32'd8);
    run_instr("beq_t",  32'h00208463, 32'd1,          0,  32'd8,  ALU_FUNC_SEQ,  1'b0, 32'd8,          5'd1, 5'd2, 5'd8,  1'b0, 32'd16);
    run_instr("beq_nt", 32'h00208463, 32'd0,          0,  32'd16, ALU_FUNC_SEQ,  1'b0, 32'd8,          5'd1, 5'd2, 5'd8,  1'b0, 32'd20);
    run_instr("bne_bk", 32'hFE209CE3, 32'd0,          0,  32'd20, ALU_FUNC_SEQ,  1'b0, 32'hFFFF_FFF8,  5'd1, 5'd2, 5'd25, 1'b0, 32'd12);
    run_instr("addi_x0",32'h00100013, 32'd7,          3,  32'd12, ALU_FUNC_ADD,  1'b1, 32'd1,          5'd0, 5'd1, 5'd0,  1'b0, 32'd16);
    run_instr("srai",   32'h4030D293, 32'h1234_5678,  0,  32'd16, ALU_FUNC_SRA,  1'b1, 32'h0000_0403,  5'd1, 5'd3, 5'd5,  1'b1, 32'd20);
    run_instr("slt",    32'h0020A333, 32'd1,          0,  32'd20, ALU_FUNC_SLT,  1'b0, 32'd0,          5'd1, 5'd2, 5'd6,  1'b1, 32'd24);

`ifdef CORE_ILLEGAL_HALT_EN
    chk("ill_req", 32'(imem_req), 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0000;
    @(negedge clk);
    @(negedge clk);
    for (int unsigned i = 0; i < 4; i++) begin
      chk("halt_flag", 32'(halt), 32'd1);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_pc", imem_addr, 32'd24);
      chk("halt_func", 32'(alu_func), 32'(ALU_FUNC_UNKNOWN));
      @(negedge clk);
    end
    #1 rst = 1'b1;
    #1;
    chk("halt_rst_flag", 32'(halt), 32'd0);
    chk("halt_rst_addr", imem_addr, 32'h0);
`else
    run_instr("ill_zero", 32'h0000_0000, 32'd1,       0,  32'd24, ALU_FUNC_UNKNOWN, 1'b0, 32'd0,     5'd0, 5'd0, 5'd0,  1'b0, 32'd28);
    run_instr("ill_f7",   32'h4020C1B3, 32'd1,       0,  32'd28, ALU_FUNC_UNKNOWN, 1'b0, 32'd0,     5'd1, 5'd2, 5'd3,  1'b0, 32'd32);
    chk("mid_req", 32'(imem_req), 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0090_0393;
    @(negedge clk);
    @(negedge clk);
    alu_result = 32'd9;
    chk("mid_exec_func", 32'(alu_func), 32'(ALU_FUNC_ADD));
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_we", 32'(rd_we), 32'd0);
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_func", 32'(alu_func), 32'(ALU_FUNC_UNKNOWN));
    chk("mid_rst_use_imm", 32'(alu_use_imm), 32'd0);
    chk("mid_rst_rd", 32'(rd_addr), 32'd0);
    chk("mid_rst_imm", imm, 32'd0);
`endif
    fetch_q.push_back(32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reboot_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    run_instr("addi2",  32'h00500093, 32'd5,          0,  32'd0,  ALU_FUNC_ADD,  1'b1, 32'd5,          5'd0, 5'd5, 5'd1,  1'b1, 32'd4);
    #1;
    chk("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
    chk("wb_q_drained", 32'(wb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
